// File: rtl/commit_unit.sv
// commit_unit: writeback/commit stage. Buffers execution-unit results in
// per-unit FIFOs, retires at most one per cycle under round-robin
// arbitration, writes the register file and releases the destination
// register in the occupancy scoreboard.

package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
endpackage

module commit_unit
    import core_config_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int DEPTH   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_UNITS-1:0]              unit_valid,
    output logic [N_UNITS-1:0]              unit_ready,
    input  logic [N_UNITS*REG_ADDR_W-1:0]   unit_rd,
    input  logic [N_UNITS*XLEN-1:0]         unit_data,
    output logic                            rf_we,
    output logic [REG_ADDR_W-1:0]           rf_addr,
    output logic [XLEN-1:0]                 rf_wdata,
    output logic [REG_ADDR_W-1:0]           address,
    output logic                            write,
    output logic                            busy,
    output logic [31:0]                     commit_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(N_UNITS);

    // FIFO storage and bookkeeping, one set per execution unit
    logic [REG_ADDR_W-1:0] r_fifo_rd   [N_UNITS][DEPTH];
    logic [XLEN-1:0]       r_fifo_data [N_UNITS][DEPTH];
    logic [PTR_W-1:0]      r_wptr      [N_UNITS];
    logic [PTR_W-1:0]      r_rptr      [N_UNITS];
    logic [CNT_W-1:0]      r_count     [N_UNITS];

    // Arbiter state and registered commit outputs
    logic [IDX_W-1:0]      r_last_grant;
    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_addr;
    logic [XLEN-1:0]       r_rf_wdata;
    logic                  r_busy;
    logic [31:0]           r_commit_cnt;

    // Combinational handshake/arbitration results
    logic [N_UNITS-1:0]    w_not_empty;
    logic [N_UNITS-1:0]    w_ready;
    logic [N_UNITS-1:0]    w_push;
    logic [N_UNITS-1:0]    w_pop;
    logic                  w_grant_valid;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;

    // Per-unit status from registered counts only; a full FIFO refuses a
    // push even when it is being popped in the same cycle.
    always_comb begin
        w_not_empty = '0;
        w_ready     = '0;
        w_push      = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            w_not_empty[i] = (r_count[i] != CNT_W'(0));
            w_ready[i]     = (r_count[i] != CNT_W'(DEPTH));
            w_push[i]      = unit_valid[i] & w_ready[i];
        end
    end

    // Round-robin pick: scan from last_grant+1 upward with wrap; scanning
    // from the lowest priority to the highest lets the highest overwrite.
    always_comb begin
        int v_idx;
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        v_idx         = 0;
        for (int k = N_UNITS; k >= 1; k--) begin
            v_idx = (int'(r_last_grant) + k) % N_UNITS;
            if (w_not_empty[v_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = IDX_W'(v_idx);
            end else begin
                w_grant_valid = w_grant_valid;
            end
        end
    end

    // Decode the grant into per-unit pop strobes and select the head entry
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            w_pop[i] = w_grant_valid && (w_grant_idx == IDX_W'(i));
        end
        w_head_rd   = r_fifo_rd[w_grant_idx][r_rptr[w_grant_idx]];
        w_head_data = r_fifo_data[w_grant_idx][r_rptr[w_grant_idx]];
    end

    // FIFO payload write at the tail; contents need no reset since the
    // counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (w_push[i]) begin
                r_fifo_rd[i][r_wptr[i]]   <= unit_rd[i*REG_ADDR_W +: REG_ADDR_W];
                r_fifo_data[i][r_wptr[i]] <= unit_data[i*XLEN +: XLEN];
            end else begin
                r_fifo_rd[i][r_wptr[i]]   <= r_fifo_rd[i][r_wptr[i]];
                r_fifo_data[i][r_wptr[i]] <= r_fifo_data[i][r_wptr[i]];
            end
        end
    end

    // FIFO pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (rst) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_count[i] <= '0;
            end else begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + PTR_W'(1);
                end else begin
                    r_wptr[i] <= r_wptr[i];
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + PTR_W'(1);
                end else begin
                    r_rptr[i] <= r_rptr[i];
                end
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Retirement: register the granted head, suppress writes to x0, count
    // every grant, and remember the winner for the next rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDX_W'(N_UNITS - 1);
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_wdata   <= '0;
            r_busy       <= 1'b0;
            r_commit_cnt <= 32'd0;
        end else begin
            r_busy <= |w_not_empty;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
                r_rf_we      <= (w_head_rd != REG_ADDR_W'(0));
                r_rf_addr    <= w_head_rd;
                r_rf_wdata   <= w_head_data;
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end else begin
                r_last_grant <= r_last_grant;
                r_rf_we      <= 1'b0;
                r_rf_addr    <= r_rf_addr;
                r_rf_wdata   <= r_rf_wdata;
                r_commit_cnt <= r_commit_cnt;
            end
        end
    end

    assign unit_ready = w_ready;
    assign rf_we      = r_rf_we;
    assign write      = r_rf_we;
    assign rf_addr    = r_rf_addr;
    assign address    = r_rf_addr;
    assign rf_wdata   = r_rf_wdata;
    assign busy       = r_busy;
    assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit (4 units, depth 2).

module tb_commit_unit;

    logic         clk;
    logic         rst;
    logic [3:0]   unit_valid;
    logic [3:0]   unit_ready;
    logic [19:0]  unit_rd;
    logic [127:0] unit_data;
    logic         rf_we;
    logic [4:0]   rf_addr;
    logic [31:0]  rf_wdata;
    logic [4:0]   address;
    logic         write;
    logic         busy;
    logic [31:0]  commit_cnt;

    int n_pass  = 0;
    int n_total = 0;

    commit_unit #(.N_UNITS(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .unit_valid (unit_valid),
        .unit_ready (unit_ready),
        .unit_rd    (unit_rd),
        .unit_data  (unit_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .address    (address),
        .write      (write),
        .busy       (busy),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_unit(input int u, input logic [4:0] rd, input logic [31:0] d);
        unit_valid[u]        = 1'b1;
        unit_rd[u*5 +: 5]    = rd;
        unit_data[u*32 +: 32] = d;
    endtask

    // Fill/rotation scenario tables (hand-derived schedule)
    int b_seq   [7] = '{0, 1, 2, 2, 3, 3, 3};
    int exp_rdy1[7] = '{1, 1, 0, 1, 0, 0, 1};
    int exp_rd  [8] = '{10, 20, 30, 11, 21, 31, 22, 23};

    initial begin
        rst        = 1'b1;
        unit_valid = 4'b0000;
        unit_rd    = 20'd0;
        unit_data  = 128'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and idle
        for (int c = 0; c < 10; c++) begin
            check("idle_ready", unit_ready, 32'hF);
            check("idle_rf_we", rf_we, 32'd0);
            check("idle_write", write, 32'd0);
            check("idle_busy", busy, 32'd0);
            check("idle_cnt", commit_cnt, 32'd0);
            tick();
        end
        check("rst_rf_addr", rf_addr, 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);

        // All four units push at once: retire 0,1,2,3
        for (int u = 0; u < 4; u++) set_unit(u, 5'(u + 1), 32'h1111_0000 + 32'(u));
        tick();
        unit_valid = 4'b0000;
        check("all4_lat_we", rf_we, 32'd0);
        check("all4_lat_busy", busy, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("all4_we", rf_we, 32'd1);
            check("all4_write", write, 32'd1);
            check("all4_addr", rf_addr, 32'(i + 1));
            check("all4_address", address, 32'(i + 1));
            check("all4_data", rf_wdata, 32'h1111_0000 + 32'(i));
            check("all4_cnt", commit_cnt, 32'(i + 1));
            check("all4_busy", busy, 32'd1);
        end
        tick();
        check("all4_end_we", rf_we, 32'd0);
        check("all4_end_busy", busy, 32'd0);
        check("all4_end_cnt", commit_cnt, 32'd4);
        check("all4_hold_addr", rf_addr, 32'd4);

        // Single push on unit 2
        set_unit(2, 5'd5, 32'hDEAD_BEEF);
        tick();
        unit_valid = 4'b0000;
        check("single_lat_we", rf_we, 32'd0);
        tick();
        check("single_we", rf_we, 32'd1);
        check("single_write", write, 32'd1);
        check("single_addr", rf_addr, 32'd5);
        check("single_address", address, 32'd5);
        check("single_data", rf_wdata, 32'hDEAD_BEEF);
        check("single_cnt", commit_cnt, 32'd5);
        tick();
        check("single_pulse_end", rf_we, 32'd0);
        check("single_write_end", write, 32'd0);
        check("single_hold_addr", rf_addr, 32'd5);
        check("single_hold_data", rf_wdata, 32'hDEAD_BEEF);

        // rd = 0 on unit 3: consumed and counted, no write/release
        set_unit(3, 5'd0, 32'h1234_5678);
        tick();
        unit_valid = 4'b0000;
        tick();
        check("x0_we", rf_we, 32'd0);
        check("x0_write", write, 32'd0);
        check("x0_cnt", commit_cnt, 32'd6);
        check("x0_addr", rf_addr, 32'd0);
        check("x0_data", rf_wdata, 32'h1234_5678);

        // Unit 1 streams while units 0 and 3 stay occupied
        for (int p = 0; p < 9; p++) begin
            unit_valid = 4'b0000;
            if (p < 2) begin
                set_unit(0, 5'(10 + p), 32'hCAFE_0000 + 32'(10 + p));
                set_unit(3, 5'(30 + p), 32'hCAFE_0000 + 32'(30 + p));
            end
            if (p < 7) begin
                set_unit(1, 5'(20 + b_seq[p]), 32'hCAFE_0000 + 32'(20 + b_seq[p]));
                check("fill_ready1", unit_ready[1], 32'(exp_rdy1[p]));
            end
            if (p == 2) check("fill_ready_vec", unit_ready, 32'h5);
            tick();
            if (p >= 1) begin
                check("fill_we", rf_we, 32'd1);
                check("fill_addr", rf_addr, 32'(exp_rd[p-1]));
                check("fill_data", rf_wdata, 32'hCAFE_0000 + 32'(exp_rd[p-1]));
                check("fill_cnt", commit_cnt, 32'(6 + p));
            end else begin
                check("fill_first_we", rf_we, 32'd0);
            end
            if (p == 8) check("fill_busy", busy, 32'd1);
        end
        unit_valid = 4'b0000;
        tick();
        check("fill_end_we", rf_we, 32'd0);
        check("fill_end_busy", busy, 32'd0);
        check("fill_end_cnt", commit_cnt, 32'd14);

        // Three results buffered, then reset discards them
        set_unit(0, 5'd7, 32'h0000_0007);
        set_unit(1, 5'd8, 32'h0000_0008);
        set_unit(2, 5'd9, 32'h0000_0009);
        tick();
        unit_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_we", rf_we, 32'd0);
        check("mrst_cnt", commit_cnt, 32'd0);
        check("mrst_ready", unit_ready, 32'hF);
        check("mrst_busy", busy, 32'd0);
        check("mrst_addr", rf_addr, 32'd0);
        check("mrst_data", rf_wdata, 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post_rst_we", rf_we, 32'd0);
            check("post_rst_write", write, 32'd0);
            check("post_rst_cnt", commit_cnt, 32'd0);
            check("post_rst_busy", busy, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
